// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 key decoder: prefix and
// status byte values, decoder state encoding, game-key indices and the
// scan-code to game-key map table.
package ps2_pkg;

    // Sequence prefixes
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Keyboard status / acknowledge bytes that carry no key information
    localparam logic [7:0] STS_BAT_OK = 8'hAA;
    localparam logic [7:0] STS_ACK    = 8'hFA;
    localparam logic [7:0] STS_RESEND = 8'hFE;
    localparam logic [7:0] STS_ECHO   = 8'hEE;
    localparam logic [7:0] STS_ERR_LO = 8'h00;
    localparam logic [7:0] STS_ERR_HI = 8'hFF;

    // The Pause key sends E1 followed by seven more bytes, none of them useful
    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    // Game keys
    localparam int NUM_KEYS  = 7;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_SPACE = 4;
    localparam int KEY_P     = 5;
    localparam int KEY_ESC   = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_code_t;

    // Entry i is the {E0 prefix, code} that identifies game key i
    localparam key_code_t KEY_MAP [NUM_KEYS] = '{
        '{ext: 1'b1, code: 8'h6B},   // Left
        '{ext: 1'b1, code: 8'h74},   // Right
        '{ext: 1'b1, code: 8'h75},   // Up (rotate)
        '{ext: 1'b1, code: 8'h72},   // Down
        '{ext: 1'b0, code: 8'h29},   // Space (drop)
        '{ext: 1'b0, code: 8'h4D},   // P (pause)
        '{ext: 1'b0, code: 8'h76}    // Esc
    };

    // True for bytes the keyboard sends about itself rather than about keys
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == STS_BAT_OK) || (b == STS_ACK) || (b == STS_RESEND) ||
               (b == STS_ECHO) || (b == STS_ERR_LO) || (b == STS_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup of a completed {ext, code} pair in the game-key map.
// Produces a one-hot key vector and a hit flag. Codes outside the table,
// including the E0 12 / E0 59 fake shifts, never hit.
module ps2_key_map
    import ps2_pkg::*;
(
    input  logic                ext,
    input  logic [7:0]          code,
    output logic [NUM_KEYS-1:0] onehot,
    output logic                hit
);

    // Compare the code against every table entry in parallel
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((ext == KEY_MAP[i].ext) && (code == KEY_MAP[i].code)) begin
                onehot[i] = 1'b1;
            end
        end
        hit = |onehot;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 sequence decoder for the Tetris controls.
// Reassembles E0 / F0 / E1 sequences into raw make/break events and keeps a
// held bitmap of game keys with one-cycle press/release edges; typematic
// repeats do not re-fire press.
// Optional feature: define PS2_DECODER_TIMEOUT_EN to abandon a partial
// sequence after TIMEOUT_CYCLES clocks of byte silence.
module ps2_key_decoder #(
`ifdef PS2_DECODER_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 200000,
`endif
    parameter int NUM_KEYS = ps2_pkg::NUM_KEYS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic [7:0]          raw_code,
    output logic                raw_ext,
    output logic                raw_brk,
    output logic                raw_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);
    import ps2_pkg::*;

    ps2_state_e          state;
    ps2_state_e          state_nxt;
    logic [2:0]          skip_cnt;
    logic [2:0]          skip_nxt;
    logic                done;
    logic                done_ext;
    logic                done_brk;
    logic                timeout_hit;
    logic [NUM_KEYS-1:0] map_onehot;
    logic                map_hit;

`ifdef PS2_DECODER_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_cnt;

    // Count byte silence while a sequence is partially received
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (byte_valid || (state == S_IDLE) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A new byte in the same cycle wins over the timeout
    assign timeout_hit = (state != S_IDLE) && !byte_valid &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout a partial sequence waits for its next byte forever
    assign timeout_hit = 1'b0;
`endif

    // Lookup uses the incoming byte so the map updates with raw_valid
    ps2_key_map u_key_map (
        .ext    (done_ext),
        .code   (byte_in),
        .onehot (map_onehot),
        .hit    (map_hit)
    );

    // Sequence state transitions and completion detection for the current byte
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        done      = 1'b0;
        done_ext  = 1'b0;
        done_brk  = 1'b0;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_in == PFX_EXT) begin
                        state_nxt = S_EXT;
                    end else if (byte_in == PFX_BRK) begin
                        state_nxt = S_BRK;
                    end else if (byte_in == PFX_PAUSE) begin
                        state_nxt = S_SKIP;
                        skip_nxt  = PAUSE_TAIL_LEN;
                    end else if (!is_status_byte(byte_in)) begin
                        done = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_in == PFX_BRK) begin
                        state_nxt = S_EXT_BRK;
                    end else if (byte_in != PFX_EXT) begin
                        done     = 1'b1;
                        done_ext = 1'b1;
                    end
                end
                S_BRK: begin
                    done     = 1'b1;
                    done_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    done     = 1'b1;
                    done_ext = 1'b1;
                    done_brk = 1'b1;
                end
                S_SKIP: begin
                    if (skip_cnt <= 3'd1) begin
                        skip_nxt  = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        skip_nxt = skip_cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    skip_nxt  = '0;
                end
            endcase
            if (done) begin
                state_nxt = S_IDLE;
            end
        end else if (timeout_hit) begin
            state_nxt = S_IDLE;
            skip_nxt  = '0;
        end
    end

    // Sequence state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Raw event registers and game-key bitmap with press/release edges
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_code    <= '0;
            raw_ext     <= 1'b0;
            raw_brk     <= 1'b0;
            raw_valid   <= 1'b0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            raw_valid   <= done;
            key_press   <= '0;
            key_release <= '0;
            if (done) begin
                raw_code <= byte_in;
                raw_ext  <= done_ext;
                raw_brk  <= done_brk;
                if (map_hit) begin
                    if (done_brk) begin
                        key_held    <= key_held & ~map_onehot;
                        key_release <= key_held & map_onehot;
                    end else begin
                        key_held  <= key_held | map_onehot;
                        key_press <= map_onehot & ~key_held;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes completed PS/2 scan-code bytes (scan code set 2) from the keyboard receiver stage and reassembles multi-byte sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence).
- Emits decoded raw make/break events and a game-key bitmap with held state plus one-cycle press/release pulses.
- Feeds the Tetris game-control logic.
- Typematic repeats are filtered, so one physical press gives exactly one press pulse.

Parameters:
- TIMEOUT_CYCLES, 200000, clk cycles of byte silence after which a partial sequence is abandoned (2 ms at 100 MHz; used only with the optional feature).
- NUM_KEYS, 7, number of mapped game keys; fixed by the key map, not meant to be overridden.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- byte_in, input, 8: received scan-code byte.
- byte_valid, input, 1: one-cycle pulse; byte_in is valid in that cycle.
- raw_code, output, 8: last completed code byte (prefixes stripped).
- raw_ext, output, 1: completed code carried the E0 prefix.
- raw_brk, output, 1: completed code was a break (F0).
- raw_valid, output, 1: one-cycle pulse when a code completes.
- key_held, output, NUM_KEYS: bitmap of game keys currently down.
- key_press, output, NUM_KEYS: one-cycle pulse on the up transition of key_held.
- key_release, output, NUM_KEYS: one-cycle pulse on the down transition of key_held.

Behaviour:
- Reset, applied on a clk edge with rst=1: all outputs 0; FSM goes to IDLE; skip counter 0.
- Reset has priority over a coincident byte_valid. The byte in that cycle is discarded.
- Key map, as bit index = code:
  - 0 = Left, E0 6B
  - 1 = Right, E0 74
  - 2 = Up (rotate), E0 75
  - 3 = Down, E0 72
  - 4 = Space (drop), 29
  - 5 = P (pause), 4D
  - 6 = Esc, 76
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to SKIP with skip counter = 7.
  - AA, FA, FE, EE, 00 and FF are keyboard status/ack bytes. They are ignored with no output and the FSM stays in IDLE.
  - Any other byte completes with ext=0, brk=0.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - Any other byte completes with ext=1, brk=0.
- BRK: any byte completes with ext=0, brk=1.
- EXT_BRK: any byte completes with ext=1, brk=1.
- SKIP:
  - Each byte decrements the skip counter.
  - When the counter reaches 0, the FSM returns to IDLE.
  - SKIP produces no output, so the Pause key is swallowed.
- Completion:
  - On the clk edge that samples byte_valid, raw_code, raw_ext and raw_brk are registered and the FSM returns to IDLE.
  - raw_valid is high for exactly the next cycle; latency is 1 cycle.
  - raw_* hold their values until the next completion.
- Map update, in the same cycle as raw_valid:
  - If the completed code matches map entry i, the held bit goes to 1 on make and 0 on break.
  - key_press[i] = make and not previously held.
  - key_release[i] = break and previously held.
  - A repeated make while held (typematic) gives no press pulse.
  - A break for a key not held gives no release pulse.
- Fake-shift codes E0 12 and E0 59 complete as raw events but never touch the map.
- At most one map bit changes per completion.
- byte_valid is never asserted on consecutive cycles; the block tolerates it, processing every pulse in order.
- Reset mid-sequence: the partial prefix is lost and the next byte is interpreted from IDLE.

Optional Feature:
- Macro PS2_DECODER_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every byte_valid and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, the skip counter is cleared and no output is produced.
  - This recovers from a byte dropped by the receiver.
- Undefined:
  - No counter exists.
  - A partial sequence waits indefinitely for the next byte.

Decomposition:
- Shared package ps2_pkg holds:
  - prefix constants (E0, F0, E1) and the status-byte constants
  - the FSM state enum
  - key index constants KEY_LEFT..KEY_ESC and NUM_KEYS
  - the scan-code map table
- One sub-module, ps2_key_map: combinational match of {ext, code} to a one-hot NUM_KEYS vector plus a hit flag. The top keeps the FSM, registers and edge logic.

Test Plan:
- Send 29, then F0 29 → raw_valid pulses twice (29/ext0/brk0, then 29/ext0/brk1); key_held[4] goes 1 then 0; key_press[4] and key_release[4] each pulse once.
- Send E0 6B three times, then E0 F0 6B → key_press[0] pulses once only; key_held[0]=1 throughout; a single key_release[0] pulse after the break.
- Send E1 14 77 E1 F0 14 F0 77, then 4D → no raw_valid during the first 8 bytes; then raw_code=4D and key_press[5] pulses.
- Send AA, then FA → no raw_valid, FSM stays in IDLE; a following 76 → key_press[6].
- Send E0, assert rst for one cycle, then send 6B → raw_valid with raw_ext=0; key_held all 0, since 6B without E0 is unmapped.
- With PS2_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send F0, wait 20 cycles, send 29 → make event (brk=0) and key_press[4] pulses.
